id_issue_controller: RTL and testbench
======================================

Name: id_issue_controller

Overview:
- Sequences the decode stage of the RISC-V pipeline.
- Owns the IF/ID and ID/EX pipeline registers, with a valid/ready handshake on each side.
- Classifies each instruction's immediate format (R/I/S/B/U/J) for the immediate generator.
- Detects load-use hazards and inserts one bubble; squashes both registers on a branch/jump flush.

Parameters:
- WIDTH, 32, PC width in bits; also the width of the counters when the optional feature is enabled.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- if_valid  input  1  IF stage offers if_instr/if_pc.
- if_instr  input  32  fetched instruction.
- if_pc  input  WIDTH  PC of if_instr.
- if_ready  output  1  controller accepts the IF offer this cycle.
- ex_ready  input  1  EX stage can take a new instruction.
- flush  input  1  taken branch/jump resolved in EX; squash ID and EX contents.
- ex_valid  output  1  ex_instr/ex_pc/ex_fmt hold a real instruction.
- ex_instr  output  32  instruction issued to EX.
- ex_pc  output  WIDTH  PC of ex_instr.
- ex_fmt  output  3  immediate format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 7=none/illegal.
- stall  output  1  load-use hazard is holding ID this cycle (combinational).

Behaviour:
- Opcode classes (instr[6:0]):
  - 0110011 → R.
  - 0010011, 0000011, 1100111 → I.
  - 0100011 → S.
  - 1100011 → B.
  - 0110111, 0010111 → U.
  - 1101111 → J.
  - anything else → 7.
- Register-use rules:
  - rs1 is used by R, I, S, B.
  - rs2 is used by R, S, B.
  - U, J and 7 use neither.
- Reset (rst=1 at an edge): ID register and EX register invalid; ex_valid=0, ex_instr=0, ex_pc=0, ex_fmt=7. if_ready=1 in the cycle after reset.
- ID register state machine (state held in id_valid):
  - EMPTY: no instruction held.
  - HELD: instruction held, waiting.
  - Transitions follow from the equations below.
- Handshake and hazard equations:
  - ex_en = !ex_valid | ex_ready.
  - hazard = id_valid & ex_valid & (ex_instr[6:0]==0000011) & (ex rd!=0) & ((uses_rs1 & rs1==ex rd) | (uses_rs2 & rs2==ex rd)), where uses_rs1/uses_rs2/rs1/rs2 are those of the held ID instruction.
  - stall = hazard.
  - advance = id_valid & ex_en & !hazard.
  - if_ready = !flush & (!id_valid | advance).
- EX register update (only when ex_en=1):
  - advance=1: loads ID contents, with ex_fmt computed from the ID instruction, and sets ex_valid=1.
  - advance=0: sets ex_valid=0 (bubble); ex_instr/ex_pc/ex_fmt hold their values.
  - ex_en=0: the EX register holds all fields.
- ID register update:
  - if_valid & if_ready: loads if_instr/if_pc and stays HELD. Accept and advance in the same cycle is allowed (back-to-back issue at 1 instr/cycle).
  - else if advance: goes EMPTY.
  - else: holds.
- Latency: an instruction accepted at edge N appears on ex_valid at edge N+1 at the earliest.
- Load-use bubble:
  - Exactly one bubble is inserted.
  - After the bubble, ex_valid=0, so hazard drops and the dependent instruction issues on the next ex_en.
  - A load followed by an instruction that reads x0 does not stall.
- flush has priority over everything at the edge:
  - ID register goes EMPTY; ex_valid=0.
  - The IF offer in that cycle is not accepted (if_ready=0).
  - Counters still update per the optional feature.
- Simultaneous flush and ex_ready=0: the EX register is still invalidated.
- rst has priority over flush.
- Reset mid-stall clears all state; no bubble or held instruction survives.
- With ex_ready=0 held indefinitely and EX valid: ID holds, if_ready=0, and there is no data loss.

Optional Feature:
- Macro: ID_ISSUE_PERF_EN.
- When defined, add outputs:
  - perf_stall_cnt  output  WIDTH  counts cycles with stall=1.
  - perf_flush_cnt  output  WIDTH  counts cycles with flush=1.
  - Both reset to 0 and wrap from all-ones to 0.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then stream: addi x1,x0,5 (0x00500093) at pc 0x0, then add x2,x1,x1 (0x00108133) at 0x4, ex_ready=1 → ex_valid high on consecutive cycles; ex_fmt=1 then 0; ex_pc 0x0, 0x4; stall never 1.
- lw x5,0(x1) (0x0000A283) then add x6,x5,x0 (0x00028333) → stall=1 for one cycle; one ex_valid=0 bubble; add issues next cycle with ex_pc=lw_pc+4.
- lw x0,0(x1) (0x0000A003) then add x6,x0,x0 → no stall.
- ex_ready=0 for 3 cycles with an instruction in EX and one in ID → if_ready=0; ex_* stable; after release, issue resumes in order with no loss or duplication.
- flush asserted while ID is HELD and EX is valid, with if_valid=1 → next cycle ex_valid=0, ID EMPTY, offered instruction not accepted; the following cycle if_ready=1.
- lui x3,0x12345 (0x123451B7), jal x1,8 (0x008000EF), opcode 0x7F → ex_fmt 4, 5, 7. With ID_ISSUE_PERF_EN defined, the load-use case gives perf_stall_cnt=1, and one flush cycle gives perf_flush_cnt=1.

Source files
------------

// File: rtl/id_issue_controller_if.sv
// Purpose: handshake bundle between the IF stage, the decode controller and the EX stage.
// Ports: IF offer (if_valid/if_instr/if_pc -> if_ready), EX side (ex_ready/flush -> ex_valid/ex_instr/ex_pc/ex_fmt), stall.
// master = pipeline neighbours (IF/EX side driving the controller), slave = id_issue_controller.
interface id_issue_controller_if #(
  parameter int WIDTH = 32
);
  logic             if_valid;
  logic [31:0]      if_instr;
  logic [WIDTH-1:0] if_pc;
  logic             if_ready;
  logic             ex_ready;
  logic             flush;
  logic             ex_valid;
  logic [31:0]      ex_instr;
  logic [WIDTH-1:0] ex_pc;
  logic [2:0]       ex_fmt;
  logic             stall;

  modport master (
    output if_valid, if_instr, if_pc, ex_ready, flush,
    input  if_ready, ex_valid, ex_instr, ex_pc, ex_fmt, stall
  );

  modport slave (
    input  if_valid, if_instr, if_pc, ex_ready, flush,
    output if_ready, ex_valid, ex_instr, ex_pc, ex_fmt, stall
  );
endinterface

// File: rtl/id_issue_controller.sv
// Purpose: RISC-V decode-stage sequencer owning the IF/ID and ID/EX registers; classifies immediate format,
//          inserts one bubble on load-use, squashes both registers on flush.
// Latency: accepted at edge N, visible on ex_valid at edge N+1 at the earliest; 1 instr/cycle sustained.
// Backpressure: ex_ready=0 with EX valid freezes EX and ID and drops if_ready; nothing is lost.
// Ports: clk, rst (sync, active-high), bus (id_issue_controller_if.slave).
// Optional: define ID_ISSUE_PERF_EN to add perf_stall_cnt / perf_flush_cnt (WIDTH bits, wrapping).
module id_issue_controller #(
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  id_issue_controller_if.slave   bus
`ifdef ID_ISSUE_PERF_EN
  ,
  output logic [WIDTH-1:0]       perf_stall_cnt,
  output logic [WIDTH-1:0]       perf_flush_cnt
`endif
);

  localparam logic [2:0] FMT_R    = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_NONE = 3'd7;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;

  typedef enum logic {
    ID_EMPTY = 1'b0,
    ID_HELD  = 1'b1
  } id_state_e;

  function automatic logic [2:0] fmt_of(input logic [6:0] op);
    case (op)
      7'b0110011:                          fmt_of = FMT_R;
      7'b0010011, 7'b0000011, 7'b1100111:  fmt_of = FMT_I;
      7'b0100011:                          fmt_of = FMT_S;
      7'b1100011:                          fmt_of = FMT_B;
      7'b0110111, 7'b0010111:              fmt_of = FMT_U;
      7'b1101111:                          fmt_of = FMT_J;
      default:                             fmt_of = FMT_NONE;
    endcase
  endfunction

  id_state_e        id_state_q, id_state_d;
  logic [31:0]      id_instr_q, id_instr_d;
  logic [WIDTH-1:0] id_pc_q,    id_pc_d;
  logic             ex_valid_q, ex_valid_d;
  logic [31:0]      ex_instr_q, ex_instr_d;
  logic [WIDTH-1:0] ex_pc_q,    ex_pc_d;
  logic [2:0]       ex_fmt_q,   ex_fmt_d;

  logic       id_valid;
  logic       ex_en;
  logic [2:0] id_fmt;
  logic [4:0] ex_rd;
  logic       uses_rs1;
  logic       uses_rs2;
  logic       hazard;
  logic       advance;
  logic       if_ready;

  // Handshake and hazard detection
  always_comb begin
    id_valid = (id_state_q == ID_HELD);
    ex_en    = !ex_valid_q || bus.ex_ready;
    id_fmt   = fmt_of(id_instr_q[6:0]);
    ex_rd    = ex_instr_q[11:7];
    uses_rs1 = (id_fmt == FMT_R) || (id_fmt == FMT_I) || (id_fmt == FMT_S) || (id_fmt == FMT_B);
    uses_rs2 = (id_fmt == FMT_R) || (id_fmt == FMT_S) || (id_fmt == FMT_B);
    // Only a load still sitting in EX can produce a value ID needs too early; x0 is never a real dependency.
    hazard   = id_valid && ex_valid_q && (ex_instr_q[6:0] == OP_LOAD) && (ex_rd != 5'd0) &&
               ((uses_rs1 && (id_instr_q[19:15] == ex_rd)) || (uses_rs2 && (id_instr_q[24:20] == ex_rd)));
    advance  = id_valid && ex_en && !hazard;
    // Accepting while advancing keeps the pipe full at one instruction per cycle.
    if_ready = !bus.flush && (!id_valid || advance);
  end

  // Next-state for both pipeline registers; flush overrides everything except reset.
  always_comb begin
    id_state_d = id_state_q;
    id_instr_d = id_instr_q;
    id_pc_d    = id_pc_q;
    ex_valid_d = ex_valid_q;
    ex_instr_d = ex_instr_q;
    ex_pc_d    = ex_pc_q;
    ex_fmt_d   = ex_fmt_q;

    if (bus.flush) begin
      id_state_d = ID_EMPTY;
      ex_valid_d = 1'b0;
    end else begin
      if (ex_en) begin
        if (advance) begin
          ex_valid_d = 1'b1;
          ex_instr_d = id_instr_q;
          ex_pc_d    = id_pc_q;
          ex_fmt_d   = id_fmt;
        end else begin
          // Bubble: payload fields keep their last value, only validity drops.
          ex_valid_d = 1'b0;
        end
      end

      case (id_state_q)
        ID_EMPTY: begin
          if (bus.if_valid && if_ready) begin
            id_state_d = ID_HELD;
            id_instr_d = bus.if_instr;
            id_pc_d    = bus.if_pc;
          end
        end
        ID_HELD: begin
          if (bus.if_valid && if_ready) begin
            id_instr_d = bus.if_instr;
            id_pc_d    = bus.if_pc;
          end else if (advance) begin
            id_state_d = ID_EMPTY;
          end
        end
        default: id_state_d = ID_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_state_q <= ID_EMPTY;
      id_instr_q <= '0;
      id_pc_q    <= '0;
      ex_valid_q <= 1'b0;
      ex_instr_q <= '0;
      ex_pc_q    <= '0;
      ex_fmt_q   <= FMT_NONE;
    end else begin
      id_state_q <= id_state_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
      ex_valid_q <= ex_valid_d;
      ex_instr_q <= ex_instr_d;
      ex_pc_q    <= ex_pc_d;
      ex_fmt_q   <= ex_fmt_d;
    end
  end

  assign bus.if_ready = if_ready;
  assign bus.stall    = hazard;
  assign bus.ex_valid = ex_valid_q;
  assign bus.ex_instr = ex_instr_q;
  assign bus.ex_pc    = ex_pc_q;
  assign bus.ex_fmt   = ex_fmt_q;

`ifdef ID_ISSUE_PERF_EN
  logic [WIDTH-1:0] perf_stall_cnt_q, perf_stall_cnt_d;
  logic [WIDTH-1:0] perf_flush_cnt_q, perf_flush_cnt_d;

  // Counters wrap naturally at all-ones; they still count during flush cycles.
  always_comb begin
    perf_stall_cnt_d = perf_stall_cnt_q + WIDTH'(hazard);
    perf_flush_cnt_d = perf_flush_cnt_q + WIDTH'(bus.flush);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt_q <= '0;
      perf_flush_cnt_q <= '0;
    end else begin
      perf_stall_cnt_q <= perf_stall_cnt_d;
      perf_flush_cnt_q <= perf_flush_cnt_d;
    end
  end

  assign perf_stall_cnt = perf_stall_cnt_q;
  assign perf_flush_cnt = perf_flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_issue_controller.sv
// Purpose: self-checking bench for id_issue_controller: directed vector table, hand sequences, random vs. model.
// Ports: none (top-level bench); drives the DUT through an id_issue_controller_if instance.
// Optional: ID_ISSUE_PERF_EN enables checks of the performance counters.
module tb_id_issue_controller;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  id_issue_controller_if #(.WIDTH(32)) bus ();

`ifdef ID_ISSUE_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  id_issue_controller #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef ID_ISSUE_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ifv;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        exr;
    logic        e_rdy;
    logic        e_stall;
    logic        e_v;
    logic [31:0] e_pc;
    logic [2:0]  e_fmt;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Apply inputs away from the active edge; outputs are then settled for checking.
  task automatic drive(input logic ifv, input logic [31:0] ins, input logic [31:0] pc,
                       input logic exr, input logic fl, input logic r);
    @(negedge clk);
    bus.if_valid = ifv;
    bus.if_instr = ins;
    bus.if_pc    = pc;
    bus.ex_ready = exr;
    bus.flush    = fl;
    rst          = r;
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [2:0] ref_fmt(input logic [31:0] ins);
    case (ins[6:0])
      7'h33:             return 3'd0;
      7'h13, 7'h03, 7'h67: return 3'd1;
      7'h23:             return 3'd2;
      7'h63:             return 3'd3;
      7'h37, 7'h17:      return 3'd4;
      7'h6F:             return 3'd5;
      default:           return 3'd7;
    endcase
  endfunction

  // Does instruction `ins` read architectural register r?
  function automatic logic reads(input logic [31:0] ins, input logic [4:0] r);
    logic [2:0] f;
    f = ref_fmt(ins);
    return ((f <= 3'd3) && (ins[19:15] == r)) || ((f == 3'd0 || f == 3'd2 || f == 3'd3) && (ins[24:20] == r));
  endfunction

  logic        m_id_v, m_ex_v;
  logic [31:0] m_id_i, m_id_pc, m_ex_i, m_ex_pc;
  logic [2:0]  m_ex_fmt;
  logic        m_haz, m_moves, m_rdy;
  logic [31:0] m_stall_cnt, m_flush_cnt;

  task automatic model_reset();
    m_id_v = 0; m_id_i = 0; m_id_pc = 0;
    m_ex_v = 0; m_ex_i = 0; m_ex_pc = 0; m_ex_fmt = 3'd7;
    m_stall_cnt = 0; m_flush_cnt = 0;
  endtask

  task automatic model_comb(input logic exr, input logic fl);
    logic ex_blocked;
    ex_blocked = m_ex_v && !exr;
    m_haz   = m_id_v && m_ex_v && (m_ex_i[6:0] == 7'h03) && (m_ex_i[11:7] != 5'd0) && reads(m_id_i, m_ex_i[11:7]);
    m_moves = m_id_v && !ex_blocked && !m_haz;
    m_rdy   = !fl && (!m_id_v || m_moves);
  endtask

  task automatic model_step(input logic ifv, input logic [31:0] ins, input logic [31:0] pc,
                            input logic exr, input logic fl, input logic r);
    if (r) begin
      model_reset();
      return;
    end
    m_stall_cnt += {31'd0, m_haz};
    m_flush_cnt += {31'd0, fl};
    if (fl) begin
      m_id_v = 0;
      m_ex_v = 0;
      return;
    end
    if (!(m_ex_v && !exr)) begin
      if (m_moves) begin
        m_ex_v = 1; m_ex_i = m_id_i; m_ex_pc = m_id_pc; m_ex_fmt = ref_fmt(m_id_i);
      end else begin
        m_ex_v = 0;
      end
    end
    if (ifv && m_rdy) begin
      m_id_v = 1; m_id_i = ins; m_id_pc = pc;
    end else if (m_moves) begin
      m_id_v = 0;
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [9];
    ops = '{7'h03, 7'h03, 7'h33, 7'h13, 7'h23, 7'h63, 7'h37, 7'h6F, 7'h7F};
    return {7'd0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'b010,
            5'($urandom_range(0, 3)), ops[$urandom_range(0, 8)]};
  endfunction

  initial begin
    n_checks = 0;
    n_errors = 0;
    bus.if_valid = 0; bus.if_instr = 0; bus.if_pc = 0; bus.ex_ready = 1; bus.flush = 0; rst = 1;

    // Reset state
    drive(0, 0, 0, 1, 0, 1);
    drive(0, 0, 0, 1, 0, 1);
    drive(0, 0, 0, 1, 0, 0);
    chk("rst_ex_valid", bus.ex_valid, 0);
    chk("rst_ex_instr", bus.ex_instr, 0);
    chk("rst_ex_pc",    bus.ex_pc,    0);
    chk("rst_ex_fmt",   bus.ex_fmt,   7);
    chk("rst_if_ready", bus.if_ready, 1);
    chk("rst_stall",    bus.stall,    0);

    // Stream, load-use, x0 load, U/J/illegal formats
    tbl[0]  = '{1, 32'h00500093, 32'h00, 1, 1, 0, 0, 32'h00, 3'd7};
    tbl[1]  = '{1, 32'h00108133, 32'h04, 1, 1, 0, 0, 32'h00, 3'd7};
    tbl[2]  = '{0, 32'h0,        32'h00, 1, 1, 0, 1, 32'h00, 3'd1};
    tbl[3]  = '{1, 32'h0000A283, 32'h08, 1, 1, 0, 1, 32'h04, 3'd0};
    tbl[4]  = '{1, 32'h00028333, 32'h0C, 1, 1, 0, 0, 32'h00, 3'd0};
    tbl[5]  = '{0, 32'h0,        32'h00, 1, 0, 1, 1, 32'h08, 3'd1};
    tbl[6]  = '{0, 32'h0,        32'h00, 1, 1, 0, 0, 32'h00, 3'd0};
    tbl[7]  = '{1, 32'h0000A003, 32'h10, 1, 1, 0, 1, 32'h0C, 3'd0};
    tbl[8]  = '{1, 32'h00000333, 32'h14, 1, 1, 0, 0, 32'h00, 3'd0};
    tbl[9]  = '{1, 32'h123451B7, 32'h18, 1, 1, 0, 1, 32'h10, 3'd1};
    tbl[10] = '{1, 32'h008000EF, 32'h1C, 1, 1, 0, 1, 32'h14, 3'd0};
    tbl[11] = '{1, 32'h0000007F, 32'h20, 1, 1, 0, 1, 32'h18, 3'd4};
    tbl[12] = '{0, 32'h0,        32'h00, 1, 1, 0, 1, 32'h1C, 3'd5};
    tbl[13] = '{0, 32'h0,        32'h00, 1, 1, 0, 1, 32'h20, 3'd7};
    tbl[14] = '{0, 32'h0,        32'h00, 1, 1, 0, 0, 32'h00, 3'd0};
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].ifv, tbl[i].instr, tbl[i].pc, tbl[i].exr, 0, 0);
      chk($sformatf("vec%0d_if_ready", i), bus.if_ready, tbl[i].e_rdy);
      chk($sformatf("vec%0d_stall", i),    bus.stall,    tbl[i].e_stall);
      chk($sformatf("vec%0d_ex_valid", i), bus.ex_valid, tbl[i].e_v);
      if (tbl[i].e_v) begin
        chk($sformatf("vec%0d_ex_pc", i),  bus.ex_pc,  tbl[i].e_pc);
        chk($sformatf("vec%0d_ex_fmt", i), bus.ex_fmt, tbl[i].e_fmt);
      end
    end
`ifdef ID_ISSUE_PERF_EN
    chk("perf_stall_after_loaduse", perf_stall_cnt, 1);
`endif

    // Backpressure: A in EX, B in ID, C offered while ex_ready=0 for 3 cycles
    drive(1, 32'h00500093, 32'h100, 1, 0, 0);
    drive(1, 32'h00A00113, 32'h104, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h00F00193, 32'h108, 0, 0, 0);
      chk("bp_if_ready", bus.if_ready, 0);
      chk("bp_ex_valid", bus.ex_valid, 1);
      chk("bp_ex_pc",    bus.ex_pc,    32'h100);
      chk("bp_ex_instr", bus.ex_instr, 32'h00500093);
    end
    drive(1, 32'h00F00193, 32'h108, 1, 0, 0);
    chk("bp_release_if_ready", bus.if_ready, 1);
    chk("bp_release_ex_pc",    bus.ex_pc,    32'h100);
    drive(0, 0, 0, 1, 0, 0);
    chk("bp_next_valid", bus.ex_valid, 1);
    chk("bp_next_pc",    bus.ex_pc,    32'h104);
    drive(0, 0, 0, 1, 0, 0);
    chk("bp_last_pc",    bus.ex_pc,    32'h108);
    drive(0, 0, 0, 1, 0, 0);
    chk("bp_drained",    bus.ex_valid, 0);

    // Flush with ID held, EX valid and an IF offer
    drive(1, 32'h00500093, 32'h200, 1, 0, 0);
    drive(1, 32'h00A00113, 32'h204, 1, 0, 0);
    drive(1, 32'h00F00193, 32'h208, 1, 1, 0);
    chk("fl_if_ready", bus.if_ready, 0);
    drive(1, 32'h00F00193, 32'h208, 1, 0, 0);
    chk("fl_ex_valid_after", bus.ex_valid, 0);
    chk("fl_if_ready_after", bus.if_ready, 1);
    drive(0, 0, 0, 1, 0, 0);
    chk("fl_id_was_empty", bus.ex_valid, 0);
    drive(0, 0, 0, 1, 0, 0);
    chk("fl_refetch_valid", bus.ex_valid, 1);
    chk("fl_refetch_pc",    bus.ex_pc,    32'h208);
`ifdef ID_ISSUE_PERF_EN
    chk("perf_flush_one", perf_flush_cnt, 1);
    chk("perf_stall_kept", perf_stall_cnt, 1);
`endif

    // Reset (with flush) during a load-use stall
    drive(1, 32'h0000A283, 32'h300, 1, 0, 0);
    drive(1, 32'h00028333, 32'h304, 1, 0, 0);
    drive(0, 0, 0, 1, 1, 1);
    chk("rs_stall_seen", bus.stall, 1);
    drive(0, 0, 0, 1, 0, 0);
    chk("rs_ex_valid", bus.ex_valid, 0);
    chk("rs_ex_pc",    bus.ex_pc,    0);
    chk("rs_ex_fmt",   bus.ex_fmt,   7);
    chk("rs_stall",    bus.stall,    0);
    chk("rs_if_ready", bus.if_ready, 1);
    drive(0, 0, 0, 1, 0, 0);
    chk("rs_no_survivor", bus.ex_valid, 0);

    // Random traffic against the model
    drive(0, 0, 0, 1, 0, 1);
    @(posedge clk);
    model_reset();
    for (int c = 0; c < 400; c++) begin
      logic ifv, exr, fl, r;
      logic [31:0] ins, pc;
      ifv = ($urandom_range(0, 3) != 0);
      exr = ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 9) == 0);
      r   = ($urandom_range(0, 49) == 0);
      ins = rand_instr();
      pc  = 32'($urandom) & 32'hFFFF_FFFC;
      drive(ifv, ins, pc, exr, fl, r);
      model_comb(exr, fl);
      chk("rnd_if_ready", bus.if_ready, m_rdy);
      chk("rnd_stall",    bus.stall,    m_haz);
      chk("rnd_ex_valid", bus.ex_valid, m_ex_v);
      chk("rnd_ex_instr", bus.ex_instr, m_ex_i);
      chk("rnd_ex_pc",    bus.ex_pc,    m_ex_pc);
      chk("rnd_ex_fmt",   bus.ex_fmt,   m_ex_fmt);
`ifdef ID_ISSUE_PERF_EN
      chk("rnd_perf_stall", perf_stall_cnt, m_stall_cnt);
      chk("rnd_perf_flush", perf_flush_cnt, m_flush_cnt);
`endif
      @(posedge clk);
      model_step(ifv, ins, pc, exr, fl, r);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
